// File: rtl/rv_commit_check_pkg.sv
// Shared types and default widths for the rv_commit_checker golden-trace checker.
// Optional halt-on-first-mismatch behaviour is enabled by RV_COMMIT_CHECK_HALT_EN.
package rv_commit_check_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int DEPTH_DEF   = 64;
    localparam int TIMEOUT_DEF = 1024;
    localparam int CW_DEF      = 16;

    // Trace entries are stored at the widest supported XLEN; narrower cores zero-extend.
    localparam int XLEN_MAX = 64;

    localparam logic [4:0] RD_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic                rd_we;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] data;
    } gold_entry_t;

endpackage

// File: rtl/rv_commit_checker_if.sv
// Core retire port as seen by the commit checker; the core is master, the checker is slave.
interface rv_commit_checker_if #(
    parameter int XLEN = 32
);
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic            retire_rd_we;
    logic [4:0]      retire_rd;
    logic [XLEN-1:0] retire_rd_data;
    logic            core_stall;

    modport master (
        output retire_valid, retire_pc, retire_rd_we, retire_rd, retire_rd_data,
        input  core_stall
    );

    modport slave (
        input  retire_valid, retire_pc, retire_rd_we, retire_rd, retire_rd_data,
        output core_stall
    );
endinterface

// File: rtl/rv_commit_gold_ram.sv
// Golden trace storage: one synchronous write port, asynchronous read at the compare index.
module rv_commit_gold_ram
    import rv_commit_check_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        we,
    input  logic [AW-1:0] waddr,
    input  gold_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output gold_entry_t rdata
);

    // No reset: contents survive rst so a trace can be re-run after re-arming.
    gold_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rv_commit_checker.sv
// In-order commit checker: compares each core retire against a golden trace entry.
// Define RV_COMMIT_CHECK_HALT_EN to halt and stall the core on the first mismatch.
module rv_commit_checker
    import rv_commit_check_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            gold_we,
    input  logic [AW-1:0]   gold_addr,
    input  logic [XLEN-1:0] gold_pc,
    input  logic            gold_rd_we,
    input  logic [4:0]      gold_rd,
    input  logic [XLEN-1:0] gold_data,
    input  logic [AW:0]     gold_len,
    rv_commit_checker_if.slave rif,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [CW-1:0]   pass_count,
    output logic [CW-1:0]   fail_count,
    output logic [AW-1:0]   mismatch_idx,
    output logic            mismatch_seen
);

    localparam int WDW = $clog2(TIMEOUT) + 1;

    state_t          state_q, state_d;
    logic [AW:0]     len_q;
    logic [AW-1:0]   idx_q;
    logic [WDW-1:0]  wd_q;
    logic [CW-1:0]   pass_cnt_q, fail_cnt_q;
    logic [AW-1:0]   midx_q;
    logic            seen_q, timeout_q;

    gold_entry_t     wr_entry, exp_p0;
    logic            start_ok, vld_p0, match_p0, last_p0, wd_exp_p0;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + CW'(1);
    endfunction

    // rd/data only matter when the instruction really writes a non-zero register.
    function automatic logic entry_match(input gold_entry_t g, input gold_entry_t r);
        logic m;
        m = (g.pc == r.pc) && (g.rd_we == r.rd_we);
        if (g.rd_we && (g.rd != RD_ZERO)) begin
            m = m && (g.rd == r.rd) && (g.data == r.data);
        end
        return m;
    endfunction

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = XLEN_MAX'(gold_pc);
        wr_entry.rd_we = gold_rd_we;
        wr_entry.rd    = gold_rd;
        wr_entry.data  = XLEN_MAX'(gold_data);
    end

    rv_commit_gold_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_gold_ram (
        .clk   (clk),
        .we    (gold_we && (state_q == ST_IDLE)),
        .waddr (gold_addr),
        .wdata (wr_entry),
        .raddr (idx_q),
        .rdata (exp_p0)
    );

    // Stage p0: retire vs expected entry, resolved combinationally and registered below.
    gold_entry_t ret_p0;
    always_comb begin
        ret_p0       = '0;
        ret_p0.pc    = XLEN_MAX'(rif.retire_pc);
        ret_p0.rd_we = rif.retire_rd_we;
        ret_p0.rd    = rif.retire_rd;
        ret_p0.data  = XLEN_MAX'(rif.retire_rd_data);
    end

    assign start_ok  = start && (state_q != ST_RUN);
    assign vld_p0    = (state_q == ST_RUN) && rif.retire_valid;
    assign match_p0  = entry_match(exp_p0, ret_p0);
    assign last_p0   = ({1'b0, idx_q} == (len_q - {{AW{1'b0}}, 1'b1}));
    assign wd_exp_p0 = (state_q == ST_RUN) && !vld_p0 && (wd_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (vld_p0) begin
`ifdef RV_COMMIT_CHECK_HALT_EN
                    if (!match_p0) begin
                        state_d = ST_HALT;
                    end else if (last_p0) begin
                        state_d = ST_DONE;
                    end
`else
                    if (last_p0) begin
                        state_d = ST_DONE;
                    end
`endif
                end else if (wd_exp_p0) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (start_ok) begin
                    state_d = (gold_len == '0) ? ST_DONE : ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        pass           = 1'b0;
        rif.core_stall = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                done = 1'b1;
                pass = !seen_q && !timeout_q;
            end
`ifdef RV_COMMIT_CHECK_HALT_EN
            ST_HALT: begin
                done           = 1'b1;
                rif.core_stall = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Stage p1: counters, first-mismatch capture and watchdog; frozen outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            idx_q      <= '0;
            wd_q       <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            midx_q     <= '0;
            seen_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (start_ok) begin
            len_q      <= gold_len;
            idx_q      <= '0;
            wd_q       <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            midx_q     <= '0;
            seen_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (vld_p0) begin
            wd_q  <= '0;
            idx_q <= idx_q + AW'(1);
            if (match_p0) begin
                pass_cnt_q <= sat_inc(pass_cnt_q);
            end else begin
                fail_cnt_q <= sat_inc(fail_cnt_q);
                if (!seen_q) begin
                    seen_q <= 1'b1;
                    midx_q <= idx_q;
                end
            end
        end else if (state_q == ST_RUN) begin
            if (wd_exp_p0) begin
                timeout_q <= 1'b1;
            end else begin
                wd_q <= wd_q + WDW'(1);
            end
        end
    end

    assign timeout       = timeout_q;
    assign pass_count    = pass_cnt_q;
    assign fail_count    = fail_cnt_q;
    assign mismatch_idx  = midx_q;
    assign mismatch_seen = seen_q;

endmodule

// File: doc/rv_commit_checker.md
# rv_commit_checker

Synthesizable, parametrised in-order commit checker for `riscv_core`. It holds a loadable golden retire trace of PC, destination register and write data. It compares every instruction the core retires against the next trace entry and keeps pass/fail counts, the first-mismatch index and a retire watchdog. It sits beside the core on its retire port, so directed programs self-check in simulation and on FPGA without per-cycle hand-written bench checks.

## Interface
- `XLEN`, 32, data/PC width
- `DEPTH`, 64, golden trace entries
- `AW`, `$clog2(DEPTH)`, trace index width
- `TIMEOUT`, 1024, max cycles between retires before abort
- `CW`, 16, pass/fail counter width

- `clk` in 1: core clock
- `rst` in 1: reset; asynchronous and active-high, one clock domain
- `start` in 1: begin checking (one-cycle pulse)
- `gold_we` in 1: golden entry write strobe
- `gold_addr` in AW: entry index
- `gold_pc` in XLEN: expected retire PC
- `gold_rd_we` in 1: expected register write enable
- `gold_rd` in 5: expected rd
- `gold_data` in XLEN: expected rd value
- `gold_len` in AW+1: number of valid entries, sampled at `start`
- `retire_valid` in 1: core retired one instruction this cycle
- `retire_pc`, `retire_rd_we`, `retire_rd`, `retire_rd_data` in XLEN/1/5/XLEN: retire info
- `busy` out 1: state is RUN
- `done` out 1: check finished (level, held until `start`/`rst`)
- `pass` out 1: `done` with zero fails and no timeout
- `timeout` out 1: watchdog expired
- `pass_count`, `fail_count` out CW: saturating counts
- `mismatch_idx` out AW: index of first mismatching entry
- `mismatch_seen` out 1: at least one mismatch
- `core_stall` out 1: stall request to core

## Operation
- States: IDLE, RUN, DONE, HALT (HALT only with macro).
- IDLE: `gold_we` writes entry `gold_addr`. Writes in any other state are ignored. `start` latches `gold_len` and goes to RUN with idx=0, counters, flags and watchdog cleared.
- `start` with `gold_len`=0: DONE next cycle, `pass`=1.
- RUN, on `retire_valid`: entry[idx] matches iff PC equal and rd_we equal. When expected rd_we=1 and rd≠0, rd and data must also be equal. When rd=0, the data compare is skipped. Match increments `pass_count`; mismatch increments `fail_count`. The first mismatch sets `mismatch_seen` and captures `mismatch_idx`. Then idx increments.
- The retire that consumes entry `gold_len`-1 moves the block to DONE.
- Watchdog clears on every retire and otherwise increments. Reaching TIMEOUT-1 goes to DONE with `timeout`=1 and `pass`=0.
- DONE: retires ignored. `start` re-arms; trace contents are preserved.
- `start` while RUN is ignored.
- Counters saturate at 2^CW-1.
- `rst` at any time: every output 0, state IDLE, idx 0. Trace RAM contents are undefined after power-up and are not cleared by reset.

## Timing
- Compare is registered. Counters and `mismatch_*` update on the clock edge that samples `retire_valid`, so they are visible the following cycle.
- `done`/`pass` assert the cycle after the final retire is sampled.
- Retire and watchdog expiry in the same cycle: the retire wins and the watchdog clears.
- One retire per cycle maximum. Back-to-back retires are supported at full rate.
- `gold_we` write is visible to compare from the next cycle.

## Configuration
- `RV_COMMIT_CHECK_HALT_EN` defined:
  - The first mismatch moves the block RUN→HALT on the compare edge.
  - `core_stall`=1 from the next cycle until `start` or `rst`.
  - `done`=1, `pass`=0, and counters freeze, so the failing state stays observable.
- `RV_COMMIT_CHECK_HALT_EN` undefined:
  - No HALT state; `core_stall` is tied 0.
  - Checking continues through mismatches to the end of the trace.

## Structure
- `rv_commit_check_pkg`:
  - state enum
  - `gold_entry_t` struct {pc, rd_we, rd, data}
  - `RD_ZERO` constant
  - default widths
- Sub-module `rv_commit_gold_ram`: DEPTH×`gold_entry_t`, one synchronous write port, asynchronous read at idx.
- FSM, compare, counters and watchdog live in the top.

## Test plan
- Load 3 entries {0x000,x2,10}, {0x004,x3,0xFFFFFFEC}, {0x008,x4,0xFFFFFFF6}. Run a core executing addi/addi/add → `done`=1, `pass`=1, `pass_count`=3, `fail_count`=0.
- Same trace with entry 1 data 0xFFFFFFEB → `fail_count`=1, `mismatch_idx`=1, `pass`=0. With macro: `core_stall`=1 the cycle after the retire at 0x004, and `pass_count` stays 1.
- Branch trace: entry {0x048,x8,1} after a bne at 0x030; core retires PC 0x034 instead → mismatch at that idx.
- Entry for sw (rd_we=0) vs retire of jalr with rd_we=0 and rd=0 and arbitrary data → match (data ignored).
- `gold_len`=5, core stops retiring after 2 → `timeout`=1 exactly TIMEOUT cycles after the last retire, `done`=1, `pass`=0.
- `rst` asserted mid-RUN after 2 retires → next cycle all outputs 0, IDLE. `start` → counts restart from 0 over the preserved trace.
